// File: rtl/ptp_ts_arb_if.sv
// Timestamp source/sink bundle for ptp_ts_arb: per-port capture inputs and one AXI-stream-style output.
// Optional PTP_TS_ARB_DROP_CNT_EN adds the per-port drop_count vector.
interface ptp_ts_arb_if #(
    parameter int PORTS     = 4,
    parameter int TS_WIDTH  = 96,
    parameter int TAG_WIDTH = 16,
    parameter int CL_PORTS  = $clog2(PORTS)
);
    logic [PORTS*TS_WIDTH-1:0]  s_ts;
    logic [PORTS*TAG_WIDTH-1:0] s_ts_tag;
    logic [PORTS-1:0]           s_ts_valid;
    logic [TS_WIDTH-1:0]        m_axis_ts;
    logic [TAG_WIDTH-1:0]       m_axis_ts_tag;
    logic [CL_PORTS-1:0]        m_axis_ts_port;
    logic                       m_axis_ts_valid;
    logic                       m_axis_ts_ready;
    logic [PORTS-1:0]           overflow;
`ifdef PTP_TS_ARB_DROP_CNT_EN
    logic [PORTS*16-1:0]        drop_count;
`endif

    modport master (
        input  s_ts, s_ts_tag, s_ts_valid, m_axis_ts_ready,
`ifdef PTP_TS_ARB_DROP_CNT_EN
        output drop_count,
`endif
        output m_axis_ts, m_axis_ts_tag, m_axis_ts_port, m_axis_ts_valid, overflow
    );

    modport slave (
        output s_ts, s_ts_tag, s_ts_valid, m_axis_ts_ready,
`ifdef PTP_TS_ARB_DROP_CNT_EN
        input  drop_count,
`endif
        input  m_axis_ts, m_axis_ts_tag, m_axis_ts_port, m_axis_ts_valid, overflow
    );
endinterface

// File: rtl/ptp_ts_arb.sv
// Round-robin merge of PORTS non-backpressurable timestamp sources into one valid/ready stream.
// Define PTP_TS_ARB_DROP_CNT_EN to add saturating 16-bit per-port drop counters.
module ptp_ts_arb #(
    parameter int PORTS     = 4,
    parameter int TS_WIDTH  = 96,
    parameter int TAG_WIDTH = 16,
    parameter int CL_PORTS  = $clog2(PORTS)
) (
    input  logic          clk,
    input  logic          rst,
    ptp_ts_arb_if.master  bus
);

    logic [TS_WIDTH-1:0]  hold_ts_p0  [PORTS];
    logic [TAG_WIDTH-1:0] hold_tag_p0 [PORTS];
    logic [PORTS-1:0]     hold_full_p0;

    logic [TS_WIDTH-1:0]  out_ts_p1;
    logic [TAG_WIDTH-1:0] out_tag_p1;
    logic [CL_PORTS-1:0]  out_port_p1;
    logic                 vld_p1;

    logic [CL_PORTS-1:0]  last_grant;
    logic [PORTS-1:0]     overflow_q;

    logic                 out_free;
    logic [CL_PORTS:0]    pick;
    logic                 grant_vld;
    logic [CL_PORTS-1:0]  grant_idx;
    logic [PORTS-1:0]     grant_oh;
    logic [PORTS-1:0]     cap;
    logic [PORTS-1:0]     drop;

    // Returns {found, index} of the first full port after 'last', wrapping around.
    function automatic logic [CL_PORTS:0] rr_pick(input logic [PORTS-1:0]    full,
                                                  input logic [CL_PORTS-1:0] last);
        logic [CL_PORTS:0] res;
        int idx;
        res = '0;
        for (int k = 1; k <= PORTS; k++) begin
            idx = (int'(last) + k) % PORTS;
            if (!res[CL_PORTS] && full[idx])
                res = {1'b1, CL_PORTS'(idx)};
        end
        return res;
    endfunction

    assign out_free  = !vld_p1 || bus.m_axis_ts_ready;
    assign pick      = rr_pick(hold_full_p0, last_grant);
    assign grant_vld = out_free && pick[CL_PORTS];
    assign grant_idx = pick[CL_PORTS-1:0];

    // A granted port frees its slot this cycle, so a same-cycle strobe is captured, not dropped.
    always_comb begin
        grant_oh = '0;
        cap      = '0;
        drop     = '0;
        for (int i = 0; i < PORTS; i++) begin
            grant_oh[i] = grant_vld && (grant_idx == CL_PORTS'(i));
            cap[i]      = bus.s_ts_valid[i] && (!hold_full_p0[i] || grant_oh[i]);
            drop[i]     = bus.s_ts_valid[i] && hold_full_p0[i] && !grant_oh[i];
        end
    end

    // Stage p0: per-port holding registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full_p0 <= '0;
            overflow_q   <= '0;
        end else begin
            hold_full_p0 <= cap | (hold_full_p0 & ~grant_oh);
            overflow_q   <= drop;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < PORTS; i++) begin
            if (cap[i]) begin
                hold_ts_p0[i]  <= bus.s_ts[i*TS_WIDTH +: TS_WIDTH];
                hold_tag_p0[i] <= bus.s_ts_tag[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    // Stage p1: output register, held stable while valid && !ready
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            last_grant <= CL_PORTS'(PORTS - 1);
        end else if (out_free) begin
            vld_p1 <= grant_vld;
            if (grant_vld)
                last_grant <= grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (grant_vld) begin
            out_ts_p1   <= hold_ts_p0[grant_idx];
            out_tag_p1  <= hold_tag_p0[grant_idx];
            out_port_p1 <= grant_idx;
        end
    end

    // Data registers carry no reset; gating by valid makes the outputs read zero when idle.
    assign bus.m_axis_ts       = vld_p1 ? out_ts_p1   : '0;
    assign bus.m_axis_ts_tag   = vld_p1 ? out_tag_p1  : '0;
    assign bus.m_axis_ts_port  = vld_p1 ? out_port_p1 : '0;
    assign bus.m_axis_ts_valid = vld_p1;
    assign bus.overflow        = overflow_q;

`ifdef PTP_TS_ARB_DROP_CNT_EN
    logic [15:0] drop_cnt [PORTS];

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        for (int i = 0; i < PORTS; i++) begin
            if (rst)
                drop_cnt[i] <= '0;
            else if (drop[i])
                drop_cnt[i] <= sat_inc(drop_cnt[i]);
        end
    end

    for (genvar g = 0; g < PORTS; g++) begin : g_drop_cnt
        assign bus.drop_count[g*16 +: 16] = drop_cnt[g];
    end
`endif

endmodule

// File: tb/tb_ptp_ts_arb.sv
// Directed self-checking bench for ptp_ts_arb (4 ports, 96-bit ts, 16-bit tag).
module tb_ptp_ts_arb;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ptp_ts_arb_if #(.PORTS(4), .TS_WIDTH(96), .TAG_WIDTH(16)) bus ();

    ptp_ts_arb #(.PORTS(4), .TS_WIDTH(96), .TAG_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        bus.s_ts_valid = '0;
    endtask

    task automatic strobe(input int p, input logic [95:0] ts, input logic [15:0] tag);
        bus.s_ts[p*96 +: 96]     = ts;
        bus.s_ts_tag[p*16 +: 16] = tag;
        bus.s_ts_valid[p]        = 1'b1;
    endtask

    task automatic do_reset;
        clear_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        bus.m_axis_ts_ready = 1'b1;
        do_reset();
        checks++;
        if (bus.m_axis_ts_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %b expected 0", bus.m_axis_ts_valid);
        end
        checks++;
        if (bus.overflow !== 4'b0000) begin
            failures++; $display("FAIL reset_overflow: got %b expected 0000", bus.overflow);
        end
        checks++;
        if (bus.m_axis_ts !== 96'h0) begin
            failures++; $display("FAIL reset_ts: got %h expected 0", bus.m_axis_ts);
        end
        checks++;
        if (bus.m_axis_ts_tag !== 16'h0) begin
            failures++; $display("FAIL reset_tag: got %h expected 0", bus.m_axis_ts_tag);
        end
        checks++;
        if (bus.m_axis_ts_port !== 2'd0) begin
            failures++; $display("FAIL reset_port: got %0d expected 0", bus.m_axis_ts_port);
        end
`ifdef PTP_TS_ARB_DROP_CNT_EN
        checks++;
        if (bus.drop_count !== 64'h0) begin
            failures++; $display("FAIL reset_drop_count: got %h expected 0", bus.drop_count);
        end
`endif
    endtask

    task automatic test_single;
        bus.m_axis_ts_ready = 1'b1;
        strobe(2, 96'h1234, 16'h00AA);
        tick();
        clear_in();
        checks++;
        if (bus.m_axis_ts_valid !== 1'b0) begin
            failures++; $display("FAIL single_latency: valid got %b expected 0", bus.m_axis_ts_valid);
        end
        tick();
        checks++;
        if (bus.m_axis_ts_valid !== 1'b1 || bus.m_axis_ts !== 96'h1234 ||
            bus.m_axis_ts_tag !== 16'h00AA || bus.m_axis_ts_port !== 2'd2) begin
            failures++;
            $display("FAIL single_word: got v=%b ts=%h tag=%h port=%0d expected v=1 ts=1234 tag=00aa port=2",
                     bus.m_axis_ts_valid, bus.m_axis_ts, bus.m_axis_ts_tag, bus.m_axis_ts_port);
        end
        tick();
        checks++;
        if (bus.m_axis_ts_valid !== 1'b0) begin
            failures++; $display("FAIL single_one_cycle: valid got %b expected 0", bus.m_axis_ts_valid);
        end
    endtask

    task automatic test_all_ports;
        logic [95:0] exp_ts;
        do_reset();
        bus.m_axis_ts_ready = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            for (int p = 0; p < 4; p++)
                strobe(p, 96'h1000 + 96'(rep*16 + p), 16'(16'h50 + p));
            tick();
            clear_in();
            checks++;
            if (bus.m_axis_ts_valid !== 1'b0) begin
                failures++; $display("FAIL all_latency: rep %0d valid got %b expected 0", rep, bus.m_axis_ts_valid);
            end
            for (int p = 0; p < 4; p++) begin
                tick();
                exp_ts = 96'h1000 + 96'(rep*16 + p);
                checks++;
                if (bus.m_axis_ts_valid !== 1'b1 || bus.m_axis_ts_port !== 2'(p) ||
                    bus.m_axis_ts !== exp_ts || bus.m_axis_ts_tag !== 16'(16'h50 + p) ||
                    bus.overflow !== 4'b0000) begin
                    failures++;
                    $display("FAIL all_order: rep %0d slot %0d got v=%b port=%0d ts=%h ovf=%b expected v=1 port=%0d ts=%h ovf=0000",
                             rep, p, bus.m_axis_ts_valid, bus.m_axis_ts_port, bus.m_axis_ts,
                             bus.overflow, p, exp_ts);
                end
            end
            tick();
            checks++;
            if (bus.m_axis_ts_valid !== 1'b0) begin
                failures++; $display("FAIL all_drained: rep %0d valid got %b expected 0", rep, bus.m_axis_ts_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        bus.m_axis_ts_ready = 1'b0;
        strobe(0, 96'hAAAA_0000, 16'h0001);
        strobe(1, 96'h0000_000A, 16'h0002);
        tick();
        clear_in();
        tick();
        checks++;
        if (bus.m_axis_ts_valid !== 1'b1 || bus.m_axis_ts_port !== 2'd0 || bus.m_axis_ts !== 96'hAAAA_0000) begin
            failures++;
            $display("FAIL bp_first: got v=%b port=%0d ts=%h expected v=1 port=0 ts=aaaa0000",
                     bus.m_axis_ts_valid, bus.m_axis_ts_port, bus.m_axis_ts);
        end
        tick();
        strobe(1, 96'h0000_000B, 16'h0003);
        tick();
        clear_in();
        checks++;
        if (bus.overflow !== 4'b0010) begin
            failures++; $display("FAIL bp_overflow: got %b expected 0010", bus.overflow);
        end
        tick();
        checks++;
        if (bus.overflow !== 4'b0000) begin
            failures++; $display("FAIL bp_overflow_pulse: got %b expected 0000", bus.overflow);
        end
        checks++;
        if (bus.m_axis_ts_valid !== 1'b1 || bus.m_axis_ts_port !== 2'd0 || bus.m_axis_ts !== 96'hAAAA_0000) begin
            failures++;
            $display("FAIL bp_stable: got v=%b port=%0d ts=%h expected v=1 port=0 ts=aaaa0000",
                     bus.m_axis_ts_valid, bus.m_axis_ts_port, bus.m_axis_ts);
        end
        bus.m_axis_ts_ready = 1'b1;
        tick();
        checks++;
        if (bus.m_axis_ts_valid !== 1'b1 || bus.m_axis_ts_port !== 2'd1 ||
            bus.m_axis_ts !== 96'h0000_000A || bus.m_axis_ts_tag !== 16'h0002) begin
            failures++;
            $display("FAIL bp_keeps_old: got v=%b port=%0d ts=%h tag=%h expected v=1 port=1 ts=a tag=0002",
                     bus.m_axis_ts_valid, bus.m_axis_ts_port, bus.m_axis_ts, bus.m_axis_ts_tag);
        end
        tick();
        checks++;
        if (bus.m_axis_ts_valid !== 1'b0) begin
            failures++; $display("FAIL bp_no_b: valid got %b expected 0", bus.m_axis_ts_valid);
        end
`ifdef PTP_TS_ARB_DROP_CNT_EN
        checks++;
        if (bus.drop_count !== 64'h0000_0000_0001_0000) begin
            failures++; $display("FAIL bp_drop_count: got %h expected 0000000000010000", bus.drop_count);
        end
`endif
    endtask

    task automatic test_recapture;
        bus.m_axis_ts_ready = 1'b1;
        strobe(0, 96'h0C0, 16'h0004);
        tick();
        strobe(0, 96'h00C, 16'h0005);
        tick();
        clear_in();
        checks++;
        if (bus.m_axis_ts_valid !== 1'b1 || bus.m_axis_ts_port !== 2'd0 ||
            bus.m_axis_ts !== 96'h0C0 || bus.overflow !== 4'b0000) begin
            failures++;
            $display("FAIL recap_old: got v=%b port=%0d ts=%h ovf=%b expected v=1 port=0 ts=c0 ovf=0000",
                     bus.m_axis_ts_valid, bus.m_axis_ts_port, bus.m_axis_ts, bus.overflow);
        end
        tick();
        checks++;
        if (bus.m_axis_ts_valid !== 1'b1 || bus.m_axis_ts_port !== 2'd0 || bus.m_axis_ts !== 96'h00C ||
            bus.m_axis_ts_tag !== 16'h0005 || bus.overflow !== 4'b0000) begin
            failures++;
            $display("FAIL recap_new: got v=%b port=%0d ts=%h tag=%h ovf=%b expected v=1 port=0 ts=c tag=0005 ovf=0000",
                     bus.m_axis_ts_valid, bus.m_axis_ts_port, bus.m_axis_ts, bus.m_axis_ts_tag, bus.overflow);
        end
        tick();
        checks++;
        if (bus.m_axis_ts_valid !== 1'b0) begin
            failures++; $display("FAIL recap_drained: valid got %b expected 0", bus.m_axis_ts_valid);
        end
    endtask

    task automatic test_fairness;
        // Ports 0 and 3 strobe on cycles 1..7 with ts = port*256 + cycle.
        logic       exp_v    [11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        int         exp_port [11] = '{0, 0, 0, 3, 0, 3, 0, 3, 0, 3, 0};
        int         exp_c    [11] = '{0, 0, 1, 1, 2, 3, 4, 5, 6, 7, 0};
        logic [3:0] exp_ovf  [11] = '{4'h0, 4'h0, 4'h8, 4'h1, 4'h8, 4'h1, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0};
        logic [95:0] exp_ts;
        do_reset();
        bus.m_axis_ts_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k <= 7) begin
                strobe(0, 96'(k), 16'h0);
                strobe(3, 96'(3*256 + k), 16'h3);
            end
            tick();
            clear_in();
            exp_ts = 96'(exp_port[k]*256 + exp_c[k]);
            checks++;
            if (bus.m_axis_ts_valid !== exp_v[k] || bus.overflow !== exp_ovf[k] ||
                (exp_v[k] && (bus.m_axis_ts_port !== 2'(exp_port[k]) || bus.m_axis_ts !== exp_ts))) begin
                failures++;
                $display("FAIL fair_cycle%0d: got v=%b port=%0d ts=%h ovf=%b expected v=%b port=%0d ts=%h ovf=%b",
                         k, bus.m_axis_ts_valid, bus.m_axis_ts_port, bus.m_axis_ts, bus.overflow,
                         exp_v[k], exp_port[k], exp_ts, exp_ovf[k]);
            end
        end
`ifdef PTP_TS_ARB_DROP_CNT_EN
        checks++;
        if (bus.drop_count !== 64'h0003_0000_0000_0003) begin
            failures++; $display("FAIL fair_drop_count: got %h expected 0003000000000003", bus.drop_count);
        end
`endif
    endtask

    task automatic test_reset_mid;
        bus.m_axis_ts_ready = 1'b0;
        for (int p = 0; p < 3; p++)
            strobe(p, 96'hD0 + 96'(p), 16'h0);
        tick();
        clear_in();
        strobe(0, 96'hD9, 16'h0);
        tick();
        clear_in();
        checks++;
        if (bus.m_axis_ts_valid !== 1'b1) begin
            failures++; $display("FAIL rmid_setup: valid got %b expected 1", bus.m_axis_ts_valid);
        end
        strobe(1, 96'hDD, 16'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_in();
        checks++;
        if (bus.m_axis_ts_valid !== 1'b0 || bus.overflow !== 4'b0000) begin
            failures++;
            $display("FAIL rmid_clear: got v=%b ovf=%b expected v=0 ovf=0000", bus.m_axis_ts_valid, bus.overflow);
        end
        bus.m_axis_ts_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (bus.m_axis_ts_valid !== 1'b0 || bus.overflow !== 4'b0000) begin
                failures++;
                $display("FAIL rmid_stale%0d: got v=%b port=%0d ovf=%b expected v=0 ovf=0000",
                         k, bus.m_axis_ts_valid, bus.m_axis_ts_port, bus.overflow);
            end
        end
    endtask

    initial begin
        rst                 = 1'b1;
        bus.s_ts            = '0;
        bus.s_ts_tag        = '0;
        bus.s_ts_valid      = '0;
        bus.m_axis_ts_ready = 1'b1;
        test_reset();
        test_single();
        test_all_ports();
        test_backpressure();
        test_recapture();
        test_fairness();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
